tri_gather: RTL and testbench

TRI_GATHER -- requirements
Module: tri_gather

---
 rtl/tri_gather.sv | 107 ++++++++++
 tb/tb_tri_gather.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tri_gather.sv
// tri_gather: packs a sample stream into A/B/C operand triplets, with flush zero-padding.
// Define TRI_GATHER_SUM_EN to add the registered out_sum = out_a + out_b + out_c.
module tri_gather #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic [N-1:0] out_a,
    output logic [N-1:0] out_b,
    output logic [N-1:0] out_c,
    output logic [1:0]   out_count,
    output logic         out_valid,
    input  logic         out_ready
`ifdef TRI_GATHER_SUM_EN
   ,output logic [N+1:0] out_sum
`endif
);
    typedef enum logic [1:0] {EMPTY, HAVE1, HAVE2, FULL} state_t;
    state_t       r_state, w_state_nx;
    logic [N-1:0] r_a, r_b, r_c, w_a_nx, w_b_nx, w_c_nx;
    logic [1:0]   r_count, w_count_nx;
    logic         w_in_xfer, w_out_xfer;

    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state == FULL);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign out_a      = r_a;
    assign out_b      = r_b;
    assign out_c      = r_c;
    assign out_count  = r_count;

    // A sample arriving with flush is loaded first, then the triplet closes.
    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_c_nx     = r_c;
        w_count_nx = r_count;
        case (r_state)
            EMPTY: if (w_in_xfer) begin
                w_a_nx     = in_data;
                w_state_nx = flush ? FULL : HAVE1;
                w_count_nx = flush ? 2'd1 : r_count;
            end
            HAVE1: if (w_in_xfer) begin
                w_b_nx     = in_data;
                w_state_nx = flush ? FULL : HAVE2;
                w_count_nx = flush ? 2'd2 : r_count;
            end else if (flush) begin
                w_b_nx     = '0;
                w_c_nx     = '0;
                w_count_nx = 2'd1;
                w_state_nx = FULL;
            end
            HAVE2: if (w_in_xfer) begin
                w_c_nx     = in_data;
                w_count_nx = 2'd3;
                w_state_nx = FULL;
            end else if (flush) begin
                w_c_nx     = '0;
                w_count_nx = 2'd2;
                w_state_nx = FULL;
            end
            FULL: if (w_out_xfer) begin
                // b/c must read zero until reloaded so a flushed triplet is padded
                w_b_nx     = '0;
                w_c_nx     = '0;
                w_count_nx = 2'd0;
                w_state_nx = EMPTY;
            end
            default: w_state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_count <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_c     <= w_c_nx;
            r_count <= w_count_nx;
        end
    end

`ifdef TRI_GATHER_SUM_EN
    logic [N+1:0] r_sum;
    assign out_sum = r_sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sum <= '0;
        else
            r_sum <= (w_state_nx == FULL) ? {2'b00, w_a_nx} + {2'b00, w_b_nx} + {2'b00, w_c_nx} : '0;
    end
`endif
endmodule

// File: tb/tb_tri_gather.sv
// tb_tri_gather: directed vector table, reset sequence and a stalled stream for tri_gather.
module tb_tri_gather;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [15:0] out_a, out_b, out_c;
    logic [1:0]  out_count;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef TRI_GATHER_SUM_EN
    logic [17:0] out_sum;
`endif

    int checks = 0;
    int errors = 0;

    tri_gather #(.N(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_count(out_count),
        .out_valid(out_valid), .out_ready(out_ready)
`ifdef TRI_GATHER_SUM_EN
       ,.out_sum(out_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        f, r, ev, er, chk;
        logic [15:0] ea, eb, ec;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [15:0] d, logic f, logic r, logic ev, logic er,
                                logic chk, logic [15:0] ea, logic [15:0] eb, logic [15:0] ec,
                                logic [1:0] ecnt);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.r = r; t.ev = ev; t.er = er; t.chk = chk;
        t.ea = ea; t.eb = eb; t.ec = ec; t.ecnt = ecnt;
        return t;
    endfunction

    function automatic logic [15:0] pat(int k);
        return 16'(k * 977 + 3);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(logic v, logic [15:0] d, logic f, logic r);
        @(negedge clk);
        in_valid = v; in_data = d; flush = f; out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(string name, logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [1:0] n);
        chk({name, "_a"}, 64'(out_a), 64'(a));
        chk({name, "_b"}, 64'(out_b), 64'(b));
        chk({name, "_c"}, 64'(out_c), 64'(c));
        chk({name, "_count"}, 64'(out_count), 64'(n));
    endtask

    initial begin
        int sent, got, cyc;
        logic xi, xo;
        logic [49:0] cap;
        // post-edge expectations; chk=0 rows only check the handshake outputs
        vecs.push_back(mk(1, 16'h0001, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0002, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0003, 0, 1, 1, 0, 1, 16'h1, 16'h2, 16'h3, 3));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'hFFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'hFFFF, 0, 0, 1, 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 16'h1234, 0, 0, 1, 0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h00AA, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h00AA, 16'h0, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h00AA, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0055, 1, 0, 1, 0, 1, 16'h00AA, 16'h0055, 16'h0, 2));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0005, 1, 0, 1, 0, 1, 16'h0005, 16'h0, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h0005, 16'h0, 16'h0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0020, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 1, 16'h0010, 16'h0020, 16'h0, 2));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0001, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0002, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 16'h0003, 1, 0, 1, 0, 1, 16'h1, 16'h2, 16'h3, 3));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk_outs("reset", 16'h0, 16'h0, 16'h0, 2'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].d, vecs[i].f, vecs[i].r);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].er));
            if (vecs[i].chk)
                chk_outs($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ecnt);
`ifdef TRI_GATHER_SUM_EN
            chk($sformatf("vec%0d_sum", i), 64'(out_sum),
                vecs[i].ev ? 64'(vecs[i].ea) + 64'(vecs[i].eb) + 64'(vecs[i].ec) : 64'd0);
`endif
        end

        step(1, 16'h0011, 0, 0);
        step(1, 16'h0022, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk_outs("midrst", 16'h0, 16'h0, 16'h0, 2'd0);
        rst = 1'b1;
        step(1, 16'h0007, 0, 0);
        step(1, 16'h0008, 0, 0);
        step(1, 16'h0009, 0, 0);
        chk("postrst_valid", 64'(out_valid), 64'd1);
        chk_outs("postrst", 16'h7, 16'h8, 16'h9, 2'd3);
        step(0, 16'h0000, 0, 1);
        chk("postrst_drain", 64'(out_valid), 64'd0);

        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 6000) begin
            @(negedge clk);
            in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
            in_data = pat(sent);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = 1'b0;
            xi = in_valid && in_ready;
            xo = out_valid && out_ready;
            cap = {out_count, out_a, out_b, out_c};
            @(posedge clk);
            #1;
            if (xi) sent++;
            if (xo) begin
                chk($sformatf("stream_t%0d", got), 64'(cap),
                    64'({2'd3, pat(3 * got), pat(3 * got + 1), pat(3 * got + 2)}));
                got++;
            end
            cyc++;
        end
        chk("stream_triplets", 64'(got), 64'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
